// File: rtl/ece453_avmm_master_if.sv
// Command/response and Avalon-MM bus bundle for ece453_avmm_master.
interface ece453_avmm_master_if;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;
    logic [BE_W-1:0]   cmd_byteenable;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_readdata;
    logic              rsp_error;

    logic [ADDR_W-1:0] master_address;
    logic              master_read;
    logic              master_write;
    logic [DATA_W-1:0] master_writedata;
    logic [BE_W-1:0]   master_byteenable;
    logic [DATA_W-1:0] master_readdata;
    logic              master_waitrequest;

    // Bridge side: accepts commands, drives the Avalon-MM master signals.
    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
        input  master_readdata, master_waitrequest,
        output cmd_ready, rsp_valid, rsp_readdata, rsp_error,
        output master_address, master_read, master_write, master_writedata, master_byteenable
    );

    // Environment side: issues commands and acts as the Avalon-MM slave.
    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
        output master_readdata, master_waitrequest,
        input  cmd_ready, rsp_valid, rsp_readdata, rsp_error,
        input  master_address, master_read, master_write, master_writedata, master_byteenable
    );
endinterface

// File: rtl/ece453_avmm_master.sv
// Single-outstanding Avalon-MM master: turns one local command into one bus
// transfer with a wait-cycle timeout, and reports the result as a one-cycle pulse.
module ece453_avmm_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    ece453_avmm_master_if.master        bus,
    output logic [15:0]                 txn_count
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned WAIT_W = 8;
    localparam int unsigned TXN_W  = 16;

    // Abort fires on the stall that would bring the wait counter up to TIMEOUT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_readdata_q, rsp_readdata_d;
    logic                rsp_error_q, rsp_error_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [TXN_W-1:0]    txn_q, txn_d;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            wait_q         <= '0;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_readdata_q <= '0;
            rsp_error_q    <= 1'b0;
            addr_q         <= '0;
            read_q         <= 1'b0;
            write_q        <= 1'b0;
            wdata_q        <= '0;
            be_q           <= '0;
            txn_q          <= '0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_readdata_q <= rsp_readdata_d;
            rsp_error_q    <= rsp_error_d;
            addr_q         <= addr_d;
            read_q         <= read_d;
            write_q        <= write_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            txn_q          <= txn_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        cmd_ready_d    = cmd_ready_q;
        rsp_valid_d    = 1'b0;
        rsp_readdata_d = rsp_readdata_q;
        rsp_error_d    = rsp_error_q;
        addr_d         = addr_q;
        read_d         = read_q;
        write_d        = write_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        txn_d          = txn_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid) begin
                    state_d     = XFER;
                    cmd_ready_d = 1'b0;
                    wait_d      = '0;
                    addr_d      = bus.cmd_address;
                    read_d      = ~bus.cmd_write;
                    write_d     = bus.cmd_write;
                    wdata_d     = bus.cmd_write ? bus.cmd_writedata : '0;
                    be_d        = bus.cmd_write ? bus.cmd_byteenable : {BE_W{1'b1}};
                end
            end
            XFER: begin
                if (!bus.master_waitrequest) begin
                    // Completion takes priority over a timeout in the same cycle.
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_error_d    = 1'b0;
                    rsp_readdata_d = read_q ? bus.master_readdata : '0;
                    read_d         = 1'b0;
                    write_d        = 1'b0;
                    txn_d          = txn_q + TXN_W'(1);
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_LAST) begin
                        state_d        = RESP;
                        rsp_valid_d    = 1'b1;
                        rsp_error_d    = 1'b1;
                        rsp_readdata_d = '0;
                        read_d         = 1'b0;
                        write_d        = 1'b0;
                    end
                end
            end
            RESP: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                read_d      = 1'b0;
                write_d     = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready         = cmd_ready_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_readdata      = rsp_readdata_q;
    assign bus.rsp_error         = rsp_error_q;
    assign bus.master_address    = addr_q;
    assign bus.master_read       = read_q;
    assign bus.master_write      = write_q;
    assign bus.master_writedata  = wdata_q;
    assign bus.master_byteenable = be_q;
    assign txn_count             = txn_q;
endmodule

// File: doc/ece453_avmm_master.md
ECE453_AVMM_MASTER -- requirements
Module: ece453_avmm_master

Interface
REQ-001 Parameter TIMEOUT, default 255: max wait cycles (8-bit compare) before a transfer is aborted.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request from local logic.
REQ-005 cmd_ready  output  1  high when a command can be accepted.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_address  input  5  target word address.
REQ-008 cmd_writedata  input  32  write data.
REQ-009 cmd_byteenable  input  4  write byte lanes.
REQ-010 rsp_valid  output  1  one-cycle pulse, transfer finished.
REQ-011 rsp_readdata  output  32  read result; valid with rsp_valid.
REQ-012 rsp_error  output  1  timeout flag; valid with rsp_valid.
REQ-013 master_address  output  5  Avalon-MM address.
REQ-014 master_read  output  1  Avalon-MM read strobe.
REQ-015 master_write  output  1  Avalon-MM write strobe.
REQ-016 master_writedata  output  32  Avalon-MM write data.
REQ-017 master_byteenable  output  4  Avalon-MM byte enables.
REQ-018 master_readdata  input  32  Avalon-MM read data, sampled when waitrequest low.
REQ-019 master_waitrequest  input  1  slave stall; high holds the transfer.
REQ-020 txn_count  output  16  count of completed non-error transfers.

Function
REQ-021 FSM states IDLE, XFER, RESP; all outputs registered.
REQ-022 IDLE: cmd_ready=1; cmd_valid=1 at edge -> latch cmd fields, go XFER.
REQ-023 XFER: cmd_ready=0; master_read=~cmd_write, master_write=cmd_write; address/writedata/byteenable held stable.
REQ-024 Reads drive master_byteenable=4'hF; master_writedata=0 on reads.
REQ-025 Transfer completes at first edge in XFER with master_waitrequest=0: capture master_readdata (reads) or 0 (writes) into rsp_readdata, rsp_error=0, go RESP.
REQ-026 Latency: cmd accepted edge N -> strobe high cycle N+1; zero-wait slave -> rsp_valid cycle N+2; cmd_ready high cycle N+3.
REQ-027 Wait counter (8-bit) clears on XFER entry, increments each XFER cycle with waitrequest=1.
REQ-028 Counter reaching TIMEOUT while waitrequest=1 -> abort: strobes low next cycle, rsp_readdata=0, rsp_error=1, go RESP.
REQ-029 Completion and timeout in same cycle (waitrequest=0 when counter==TIMEOUT): completion wins, rsp_error=0.
REQ-030 RESP: rsp_valid=1 for exactly one cycle, strobes low, then IDLE; rsp_readdata/rsp_error hold until next RESP.
REQ-031 cmd_valid while cmd_ready=0 ignored; no queueing.
REQ-032 master_read and master_write never high simultaneously; both low outside XFER.
REQ-033 txn_count increments by 1 on each RESP with rsp_error=0; wraps 16'hFFFF -> 16'h0000.

Reset
REQ-034 reset=1 at edge -> state IDLE, cmd_ready=1, rsp_valid=0, rsp_error=0, rsp_readdata=0, all master_* outputs 0, txn_count=0, wait counter=0.
REQ-035 Reset during XFER or RESP aborts silently: strobes low next cycle, no rsp_valid pulse.

Verification
REQ-036 Read addr 0, zero-wait slave returning 32'hECE45318 -> master_read one cycle, rsp_valid at N+2, rsp_readdata=32'hECE45318, rsp_error=0, txn_count=1.
REQ-037 Write addr 1, data 32'h00000003, be 4'hF, waitrequest high 3 cycles -> master_write high 4 cycles, signals stable, rsp_valid once, rsp_readdata=0.
REQ-038 Read with waitrequest stuck high, TIMEOUT=255 -> strobe deasserts after 255 stall cycles, rsp_error=1, rsp_readdata=0, txn_count unchanged.
REQ-039 cmd_valid held high continuously with 3 distinct cmds -> exactly one accept per IDLE visit, strobes never overlap, 3 rsp_valid pulses in order.
REQ-040 Assert reset mid-XFER -> next cycle master_read=0, master_write=0, cmd_ready=1, no rsp_valid, txn_count=0.
REQ-041 Preload txn_count path with 65536 successful transfers -> txn_count wraps to 0.
